// File: rtl/alu.sv
// 32-bit execute-stage ALU: combinational result/flags plus an enabled,
// synchronously reset registered copy for pipelined consumers.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [2:0]  alu_ctrl,
  input  logic        en,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic [31:0] result_q,
  output logic        zero_q,
  output logic        overflow_q
);

  localparam int unsigned W = 32;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_RSVD = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic [W-1:0] w_sum;
  logic [W-1:0] w_diff;
  logic         w_ovf_add;
  logic         w_ovf_sub;
  logic         w_lt;

  // Separate adder and subtractor; SUB is a + ~b + 1.
  assign w_sum     = src_a + src_b;
  assign w_diff    = src_a + ~src_b + W'(1);
  assign w_ovf_add = (src_a[W-1] == src_b[W-1]) && (w_sum[W-1]  != src_a[W-1]);
  assign w_ovf_sub = (src_a[W-1] != src_b[W-1]) && (w_diff[W-1] != src_a[W-1]);
  // Signed less-than stays correct even when the subtraction overflows.
  assign w_lt      = w_diff[W-1] ^ w_ovf_sub;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_ctrl)
      OP_AND:  result = src_a & src_b;
      OP_OR:   result = src_a | src_b;
      OP_ADD:  begin
        result   = w_sum;
        overflow = w_ovf_add;
      end
      OP_SUB:  begin
        result   = w_diff;
        overflow = w_ovf_sub;
      end
      OP_SLT:  result = {{(W-1){1'b0}}, w_lt};
      OP_ANDN: result = src_a & ~src_b;
      OP_ORN:  result = src_a | ~src_b;
      OP_RSVD: result = '0;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  // Reset state mirrors a zero result: result_q=0, zero_q=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else if (en) begin
      result_q   <= result;
      zero_q     <= zero;
      overflow_q <= overflow;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Randomized self-checking bench for alu against a signed-arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [2:0]  alu_ctrl;
  logic        en;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic [31:0] result_q;
  logic        zero_q;
  logic        overflow_q;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_res_q;
  logic        exp_zero_q;
  logic        exp_ovf_q;

  alu dut (
    .clk        (clk),
    .rst        (rst),
    .src_a      (src_a),
    .src_b      (src_b),
    .alu_ctrl   (alu_ctrl),
    .en         (en),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .result_q   (result_q),
    .zero_q     (zero_q),
    .overflow_q (overflow_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: overflow judged by whether the true signed sum leaves the 32-bit range.
  task automatic model(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic ovf);
    longint sa;
    longint sb;
    longint t;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 32'h0;
    ovf = 1'b0;
    case (ctrl)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b010: begin
        t   = sa + sb;
        res = 32'(t);
        ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'b110: begin
        t   = sa - sb;
        res = 32'(t);
        ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'b111: res = (sa < sb) ? 32'd1 : 32'd0;
      3'b100: res = a & ~b;
      3'b101: res = a | ~b;
      default: res = 32'h0;
    endcase
  endtask

  // One cycle: drive at negedge, check comb outputs, then check registered outputs after the edge.
  task automatic step(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                      input logic e, input logic r);
    logic [31:0] er;
    logic        eo;
    @(negedge clk);
    alu_ctrl = ctrl;
    src_a    = a;
    src_b    = b;
    en       = e;
    rst      = r;
    model(ctrl, a, b, er, eo);
    #1;
    chk("result", result, er);
    chk("zero", 32'(zero), 32'(er == 32'h0));
    chk("overflow", 32'(overflow), 32'(eo));
    @(posedge clk);
    #1;
    if (r) begin
      exp_res_q  = 32'h0;
      exp_zero_q = 1'b1;
      exp_ovf_q  = 1'b0;
    end else if (e) begin
      exp_res_q  = er;
      exp_zero_q = (er == 32'h0);
      exp_ovf_q  = eo;
    end
    chk("result_q", result_q, exp_res_q);
    chk("zero_q", 32'(zero_q), 32'(exp_zero_q));
    chk("overflow_q", 32'(overflow_q), 32'(exp_ovf_q));
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [6];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF;
    corners[5] = 32'h8000_0001;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom();
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; alu_ctrl = 3'b000; src_a = '0; src_b = '0;
    exp_res_q = 32'h0; exp_zero_q = 1'b1; exp_ovf_q = 1'b0;

    // Reset with a non-zero operation pending: comb path unaffected, registers reset.
    step(3'b010, 32'd10, 32'd20, 1'b0, 1'b1);
    chk("reset_result_q", result_q, 32'h0);
    chk("reset_zero_q", 32'(zero_q), 32'd1);

    // Directed vectors from the test plan.
    step(3'b010, 32'd10, 32'd20, 1'b1, 1'b0);
    chk("add_reg_30", result_q, 32'd30);
    step(3'b110, 32'd30, 32'd30, 1'b1, 1'b0);
    step(3'b110, 32'h8000_0000, 32'd1, 1'b1, 1'b0);
    chk("sub_ovf_reg", 32'(overflow_q), 32'd1);
    step(3'b000, 32'hFF00, 32'h0FF0, 1'b0, 1'b0);
    step(3'b001, 32'hFF00, 32'h00FF, 1'b0, 1'b0);
    step(3'b100, 32'hFF00, 32'h0FF0, 1'b0, 1'b0);
    step(3'b101, 32'hFF00, 32'h0FF0, 1'b0, 1'b0);
    step(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    step(3'b111, 32'd5, 32'd10, 1'b1, 1'b0);
    step(3'b111, -32'sd5, 32'd3, 1'b1, 1'b0);
    step(3'b111, 32'd3, -32'sd5, 1'b1, 1'b0);
    step(3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    chk("slt_extreme", result_q, 32'd1);
    step(3'b111, 32'd7, 32'd7, 1'b1, 1'b0);
    step(3'b010, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0);
    step(3'b010, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    // Hold with changing inputs, then reset winning over enable.
    step(3'b010, 32'd100, 32'd5, 1'b1, 1'b0);
    step(3'b001, 32'hAAAA_0000, 32'h0000_5555, 1'b0, 1'b0);
    step(3'b110, 32'h8000_0000, 32'd1, 1'b0, 1'b0);
    chk("hold_105", result_q, 32'd105);
    step(3'b010, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b1);
    chk("rst_over_en", result_q, 32'h0);

    // Randomized traffic with occasional reset and random enable.
    for (int i = 0; i < 400; i++) begin
      step(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
           1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

32-bit single-cycle arithmetic/logic unit for the processor datapath execute stage. Computes AND, OR, ADD, SUB and signed set-less-than on two 32-bit operands under a 3-bit control code, with a combinational result and zero flag for same-cycle branch and address decisions. A registered copy of the result and flags is provided for pipelined consumers.

## Interface
- No parameters; data width is fixed at 32 bits.
- clk  input  1  single clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- src_a  input  32  operand A.
- src_b  input  32  operand B.
- alu_ctrl  input  3  operation select (see Operation).
- en  input  1  capture enable for the registered outputs.
- result  output  32  combinational operation result.
- zero  output  1  combinational; 1 when result == 0.
- overflow  output  1  combinational; signed overflow for ADD/SUB, 0 otherwise.
- result_q  output  32  registered result.
- zero_q  output  1  registered zero flag.
- overflow_q  output  1  registered overflow flag.

## Operation
- alu_ctrl 000 AND: result = src_a & src_b.
- 001 OR: result = src_a | src_b.
- 010 ADD: result = src_a + src_b, modulo 2^32; carry-out discarded.
- 110 SUB: result = src_a - src_b, modulo 2^32, computed as src_a + ~src_b + 1.
- 111 SLT: result = {31'b0, lt}. lt = 1 when $signed(src_a) < $signed(src_b), computed as sign(src_a - src_b) XOR signed-overflow of that subtraction. This gives a correct result across the full range, e.g. 0x80000000 < 0x7FFFFFFF yields 1.
- 100 AND-NOT: result = src_a & ~src_b.
- 101 OR-NOT: result = src_a | ~src_b.
- 011 reserved: result = 0, overflow = 0.
- zero = (result == 32'h0) for every code, including SLT and the reserved code (reserved code forces zero = 1).
- overflow:
  - ADD: set when both operand signs are equal and the result sign differs.
  - SUB: set when operand signs differ and the result sign differs from src_a.
  - SLT: 0 at the output, although the subtraction overflow is still used internally.
  - All logic codes: 0.
- X-free: no latches; every code drives defined outputs.

## Timing
- result, zero, overflow: purely combinational from src_a/src_b/alu_ctrl. Valid within the same cycle, with no dependence on clk, rst or en.
- result_q/zero_q/overflow_q update at the rising clk edge. Priority: rst, then en.
  - rst=1: result_q = 0, zero_q = 1, overflow_q = 0. The reset state is consistent with a zero result.
  - rst=0, en=1: capture result, zero, overflow. Latency is 1 cycle.
  - rst=0, en=0: hold previous values.
- rst asserted mid-stream overrides en in that cycle. Combinational outputs are unaffected by rst.
- Operand or control changes between edges do not disturb the registered outputs.

## Test plan
- ADD: src_a=10, src_b=20, ctrl=010 -> result=30, zero=0, overflow=0. Pulse en -> result_q=30 next edge.
- SUB with zero: src_a=30, src_b=30, ctrl=110 -> result=0, zero=1. Also 0x80000000 - 1 -> result=0x7FFFFFFF, overflow=1.
- Logic: 0xFF00 & 0x0FF0 (000) -> 0x0F00; 0xFF00 | 0x00FF (001) -> 0xFFFF; 0xFF00 & ~0x0FF0 (100) -> 0xF000; ctrl=011 -> 0, zero=1.
- SLT: (5,10) -> 1; (-5,3) -> 1; (3,-5) -> 0; (0x80000000, 0x7FFFFFFF) -> 1; (7,7) -> 0 with zero=1.
- ADD overflow: 0x7FFFFFFF + 1 -> 0x80000000, overflow=1; 0xFFFFFFFF + 1 -> 0, zero=1, overflow=0.
- Registers:
  - rst=1 for one edge -> result_q=0, zero_q=1, overflow_q=0.
  - en=0 with changing inputs -> registered outputs hold.
  - rst and en both 1 -> reset wins.
